stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Timekeeping stage directly downstream of the stopwatch tick generator. Consumes the tenth-second square-wave tick and counts elapsed time in BCD (MM:SS.t) under start/stop, lap and clear control. Feeds the display/segment driver with either live or lap-frozen digits.

Parameters:
MAX_MIN, 59, highest minute value before wrap to 00:00.0; legal range 1..99.

Ports:
clk  input  1  system clock, shared with the tick generator; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
tick_in  input  1  tenth-second square wave from the tick generator, synchronous to clk; each rising edge is one count.
start_stop  input  1  debounced level button; each rising edge toggles run/pause.
lap  input  1  debounced level button; each rising edge toggles display freeze.
clear  input  1  debounced level button; level-sensitive, zeroes the count and returns to IDLE.
d_tenth  output  4  displayed tenths digit, BCD 0-9.
d_sec_lo  output  4  displayed seconds ones, BCD 0-9.
d_sec_hi  output  3  displayed seconds tens, 0-5.
d_min_lo  output  4  displayed minutes ones, BCD 0-9.
d_min_hi  output  4  displayed minutes tens, 0-9 (bounded by MAX_MIN).
running  output  1  high in RUN or LAP.
lap_active  output  1  high in LAP (display frozen).
rollover  output  1  one-cycle pulse when the count wraps from MAX_MIN:59.9 to 00:00.0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all live and lap digits 0; all outputs 0; edge-detect registers 0.
- Edge detection: tick_in, start_stop and lap each registered once. rise = in & ~in_q. Edge seen in cycle N acts at the end of cycle N. Outputs are registered and visible in N+1.
- States are IDLE, RUN, PAUSE and LAP. Encoding lives in the package.
  - IDLE: no counting. start rise -> RUN. lap is ignored.
  - RUN: count on each tick rise. start rise -> PAUSE. lap rise -> LAP, capturing the live digits into the lap register that same edge.
  - PAUSE: no counting. start rise -> RUN. lap is ignored.
  - LAP: counting continues and the display shows the lap register. lap rise -> RUN, display live again. start rise -> PAUSE, display live again.
  - clear=1 in any state, sampled each cycle: -> IDLE, live and lap digits = 0. Clear has priority over every other event in the same cycle.
- Same-cycle events:
  - A tick rise in the same cycle as a start or lap rise is counted according to the current state. Example: RUN + start rise + tick rise counts once, then enters PAUSE.
  - start and lap rising in the same cycle: start wins and lap is dropped.
  - LAP + lap rise + tick rise: the counter increments and the display returns to live, showing the incremented value.
- Counting is a cascaded BCD chain: tenth 9->0 carries to sec_lo; sec_lo 9->0 carries to sec_hi; sec_hi 5->0 carries to minutes.
- Minutes count 00..MAX_MIN in BCD. At MAX_MIN:59.9, a tick gives 00:00.0 and asserts rollover for exactly one cycle. Counting continues.
- Display mux: d_* = lap register when in LAP, else live digits.
- Button held high: only one action per rising edge; a held level never repeats.
- Illegal state encoding: recovers to IDLE with digits cleared.

Decomposition:
- stopwatch_pkg holds:
  - state enum/localparams;
  - digit max constants (9, 5);
  - BCD digit widths.
- Natural sub-module: bcd_digit (parameters WIDTH and MAX; ports clk, rst_n, clr, inc, value, carry). Instantiated five times and chained by carry.
- Minutes tens uses MAX derived from MAX_MIN/10. The terminal check for the whole chain is done in stopwatch_core.

Test Plan:
- Reset mid-count: run to 00:03.4, pulse rst_n low for 1 cycle -> all digits 0 immediately (async), running=0, state IDLE; later tick rises produce no count.
- Basic run: start rise, then 10 tick rises -> 00:01.0. Then 600 more -> 01:01.0, running=1. start rise, then 5 ticks -> still 01:01.0, running=0.
- Lap freeze: RUN at 00:02.3, lap rise -> display holds 00:02.3, lap_active=1. 7 ticks later, lap rise -> display shows 00:03.0.
- Wrap with MAX_MIN=1: run 1199 ticks -> 01:59.9. 1 more tick -> 00:00.0, rollover high exactly 1 cycle, running stays 1.
- Simultaneous events: in RUN, start rise + tick rise in same cycle -> +1 count, then PAUSE. clear + tick + start in same cycle -> 00:00.0, IDLE.
- Held buttons: start_stop held high 100 cycles across 2 ticks -> single transition to RUN, 2 counts. clear held -> stays IDLE at zero; ticks and starts are ignored while it is held.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_t;

  localparam int DIGIT_W    = 4;
  localparam int SEC_HI_W   = 3;
  localparam int MAX_DIGIT  = 9;
  localparam int MAX_SEC_HI = 5;

  // One complete MM:SS.t reading, used for both the live count and the lap snapshot.
  typedef struct packed {
    logic [DIGIT_W-1:0]  min_hi;
    logic [DIGIT_W-1:0]  min_lo;
    logic [SEC_HI_W-1:0] sec_hi;
    logic [DIGIT_W-1:0]  sec_lo;
    logic [DIGIT_W-1:0]  tenth;
  } bcd_time_t;

  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD counter digit: counts 0..MAX and emits a carry on the wrapping increment.
module bcd_digit #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign carry = inc && (value == MAX_V);

  // Digit register: clear wins over increment; an out-of-range value wraps to zero on the next increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      if (value >= MAX_V) begin
        value <= '0;
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: counts tenth-second ticks in BCD under start/stop, lap and clear control.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                start_stop,
  input  logic                lap,
  input  logic                clear,
  output logic [DIGIT_W-1:0]  d_tenth,
  output logic [DIGIT_W-1:0]  d_sec_lo,
  output logic [SEC_HI_W-1:0] d_sec_hi,
  output logic [DIGIT_W-1:0]  d_min_lo,
  output logic [DIGIT_W-1:0]  d_min_hi,
  output logic                running,
  output logic                lap_active,
  output logic                rollover
);

  localparam int               MIN_HI_MAX  = MAX_MIN / 10;
  localparam logic [DIGIT_W-1:0] MIN_HI_TERM = DIGIT_W'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MIN_LO_TERM = DIGIT_W'(MAX_MIN % 10);

  sw_state_t state;
  bcd_time_t live;
  bcd_time_t lap_reg;

  logic tick_q, start_q, lap_q;
  logic tick_rise, start_rise, lap_rise;
  logic count_en, at_terminal, wrap, illegal, digit_clr;
  logic c_tenth, c_sec_lo, c_sec_hi, c_min_lo, c_min_hi;

  assign tick_rise  = tick_in    & ~tick_q;
  assign start_rise = start_stop & ~start_q;
  assign lap_rise   = lap        & ~lap_q;

  // One-cycle history of each edge-detected input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      tick_q  <= tick_in;
      start_q <= start_stop;
      lap_q   <= lap;
    end
  end

  // Flag any state encoding outside the enumerated set so the datapath can be scrubbed.
  always_comb begin
    illegal = 1'b0;
    case (state)
      ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP: illegal = 1'b0;
      default:                           illegal = 1'b1;
    endcase
  end

  assign count_en    = tick_rise & is_counting(state) & ~clear;
  assign at_terminal = (live.tenth  == DIGIT_W'(MAX_DIGIT))   &&
                       (live.sec_lo == DIGIT_W'(MAX_DIGIT))   &&
                       (live.sec_hi == SEC_HI_W'(MAX_SEC_HI)) &&
                       (live.min_lo == MIN_LO_TERM)           &&
                       (live.min_hi == MIN_HI_TERM);
  // A carry out of the top digit can only follow a corrupted count, but it wraps the same way.
  assign wrap        = (count_en & at_terminal) | c_min_hi;
  assign digit_clr   = clear | wrap | illegal;

  bcd_digit #(.WIDTH(DIGIT_W), .MAX(MAX_DIGIT)) u_tenth (
    .clk(clk), .rst_n(rst_n), .clr(digit_clr), .inc(count_en),
    .value(live.tenth), .carry(c_tenth)
  );

  bcd_digit #(.WIDTH(DIGIT_W), .MAX(MAX_DIGIT)) u_sec_lo (
    .clk(clk), .rst_n(rst_n), .clr(digit_clr), .inc(c_tenth),
    .value(live.sec_lo), .carry(c_sec_lo)
  );

  bcd_digit #(.WIDTH(SEC_HI_W), .MAX(MAX_SEC_HI)) u_sec_hi (
    .clk(clk), .rst_n(rst_n), .clr(digit_clr), .inc(c_sec_lo),
    .value(live.sec_hi), .carry(c_sec_hi)
  );

  bcd_digit #(.WIDTH(DIGIT_W), .MAX(MAX_DIGIT)) u_min_lo (
    .clk(clk), .rst_n(rst_n), .clr(digit_clr), .inc(c_sec_hi),
    .value(live.min_lo), .carry(c_min_lo)
  );

  bcd_digit #(.WIDTH(DIGIT_W), .MAX(MIN_HI_MAX)) u_min_hi (
    .clk(clk), .rst_n(rst_n), .clr(digit_clr), .inc(c_min_lo),
    .value(live.min_hi), .carry(c_min_hi)
  );

  // Control FSM with registered status flags and the lap snapshot; clear beats every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_rise) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (lap_rise) begin
            state      <= ST_LAP;
            lap_active <= 1'b1;
            lap_reg    <= live;
          end
        end
        ST_PAUSE: begin
          if (start_rise) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_LAP: begin
          if (start_rise) begin
            state      <= ST_PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_rise) begin
            state      <= ST_RUN;
            lap_active <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
          lap_reg    <= '0;
        end
      endcase
    end
  end

  // Single-cycle wrap indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rollover <= 1'b0;
    end else begin
      rollover <= wrap;
    end
  end

  assign d_tenth  = lap_active ? lap_reg.tenth  : live.tenth;
  assign d_sec_lo = lap_active ? lap_reg.sec_lo : live.sec_lo;
  assign d_sec_hi = lap_active ? lap_reg.sec_hi : live.sec_hi;
  assign d_min_lo = lap_active ? lap_reg.min_lo : live.min_lo;
  assign d_min_hi = lap_active ? lap_reg.min_hi : live.min_hi;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core built with MAX_MIN=1 so the minute wrap is reachable quickly.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] d_tenth, d_sec_lo, d_min_lo, d_min_hi;
  logic [2:0] d_sec_hi;
  logic       running, lap_active, rollover;
  logic [19:0] disp;

  int check_count = 0;
  int pass_count  = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  stopwatch_core #(.MAX_MIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
    .lap(lap), .clear(clear),
    .d_tenth(d_tenth), .d_sec_lo(d_sec_lo), .d_sec_hi(d_sec_hi),
    .d_min_lo(d_min_lo), .d_min_hi(d_min_hi),
    .running(running), .lap_active(lap_active), .rollover(rollover)
  );

  // Display packed as hex MMSST so 01:59.9 reads 20'h01599.
  assign disp = {d_min_hi, d_min_lo, 1'b0, d_sec_hi, d_sec_lo, d_tenth};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Hold the given inputs for one cycle, then drop them for one cycle.
  task automatic applyStimulus(input logic t, input logic s, input logic l, input logic c);
    tick_in = t; start_stop = s; lap = l; clear = c;
    @(negedge clk);
    tick_in = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic runTicks(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_disp", disp, 20'h00000);
    checkOutput("reset_running", running, 1'b0);
    checkOutput("reset_lap_active", lap_active, 1'b0);
    checkOutput("reset_rollover", rollover, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle ignores ticks and lap
    runTicks(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_no_count", disp, 20'h00000);
    checkOutput("idle_lap_ignored", lap_active, 1'b0);

    // Basic run
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_running", running, 1'b1);
    runTicks(10);
    checkOutput("run_10", disp, 20'h00010);
    runTicks(600);
    checkOutput("run_610", disp, 20'h01010);
    checkOutput("run_610_running", running, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(5);
    checkOutput("pause_hold", disp, 20'h01010);
    checkOutput("pause_running", running, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_lap_ignored", lap_active, 1'b0);

    // Clear back to idle, then async reset mid-count
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_disp", disp, 20'h00000);
    checkOutput("clear_running", running, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(34);
    checkOutput("pre_reset", disp, 20'h00034);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_disp", disp, 20'h00000);
    checkOutput("async_reset_running", running, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runTicks(4);
    checkOutput("post_reset_idle", disp, 20'h00000);

    // Lap freeze
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(23);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_capture", disp, 20'h00023);
    checkOutput("lap_active_on", lap_active, 1'b1);
    runTicks(7);
    checkOutput("lap_frozen", disp, 20'h00023);
    checkOutput("lap_running", running, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_release", disp, 20'h00030);
    checkOutput("lap_active_off", lap_active, 1'b0);

    // LAP + lap rise + tick: increments and shows live
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTicks(1);
    checkOutput("lap2_frozen", disp, 20'h00030);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_tick_release", disp, 20'h00032);
    checkOutput("lap_tick_inactive", lap_active, 1'b0);

    // RUN + start + tick counts once then pauses
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("start_tick_count", disp, 20'h00033);
    checkOutput("start_tick_paused", running, 1'b0);
    runTicks(2);
    checkOutput("start_tick_hold", disp, 20'h00033);

    // start and lap together in RUN: start wins
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("start_lap_running", running, 1'b0);
    checkOutput("start_lap_no_lap", lap_active, 1'b0);

    // clear + tick + start together
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_running", running, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clear_priority_disp", disp, 20'h00000);
    checkOutput("clear_priority_running", running, 1'b0);
    runTicks(3);
    checkOutput("clear_priority_idle", disp, 20'h00000);

    // Wrap at 01:59.9
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(1199);
    checkOutput("pre_wrap", disp, 20'h01599);
    checkOutput("pre_wrap_rollover", rollover, 1'b0);
    tick_in = 1'b1;
    @(negedge clk);
    checkOutput("wrap_disp", disp, 20'h00000);
    checkOutput("wrap_rollover", rollover, 1'b1);
    checkOutput("wrap_running", running, 1'b1);
    tick_in = 1'b0;
    @(negedge clk);
    checkOutput("wrap_rollover_drop", rollover, 1'b0);
    runTicks(1);
    checkOutput("post_wrap_count", disp, 20'h00001);

    // Held start button across two ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    start_stop = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick_in = (i == 20 || i == 60);
      @(negedge clk);
    end
    tick_in = 1'b0;
    start_stop = 1'b0;
    @(negedge clk);
    checkOutput("held_start_running", running, 1'b1);
    checkOutput("held_start_count", disp, 20'h00002);

    // Held clear swallows ticks and starts
    clear = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick_in = i[0];
      start_stop = (i % 10) < 5;
      @(negedge clk);
    end
    checkOutput("held_clear_disp", disp, 20'h00000);
    checkOutput("held_clear_running", running, 1'b0);
    tick_in = 1'b0;
    start_stop = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    runTicks(2);
    checkOutput("after_clear_idle", disp, 20'h00000);
    checkOutput("after_clear_running", running, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
